// File: rtl/ladybird_initiator_pkg.sv
// Shared types for the ladybird bus initiator.
// FSM state enum, command bundle, default timeout constant.
package ladybird_initiator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RDWAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int CMD_W = $bits(cmd_t);

  // A zero strobe mask marks a read.
  function automatic logic is_read(cmd_t c);
    return c.wstrb == 4'h0;
  endfunction

endpackage

// File: rtl/ladybird_bus_interface.sv
// Ladybird request/grant bus.
// primary drives req/addr/wstrb/wdata; secondary answers gnt/rdgnt/rdata.
interface ladybird_bus_interface;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        gnt;
  logic        rdgnt;
  logic [31:0] rdata;

  modport primary (
    output req, addr, wstrb, wdata,
    input  gnt, rdgnt, rdata
  );

  modport secondary (
    input  req, addr, wstrb, wdata,
    output gnt, rdgnt, rdata
  );
endinterface

// File: rtl/ladybird_initiator_fifo.sv
// Command FIFO: clk, rst (async high), push/wdata, pop/rdata, full, empty.
// Pointers carry an extra wrap bit to tell full from empty.
module ladybird_initiator_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ladybird_bus_initiator.sv
// Bus initiator: queues commands, runs one bus transaction at a time.
// Ports: clk, rst, bus (primary), cmd_*, rsp_*; macro LADYBIRD_INITIATOR_TIMEOUT_EN.
module ladybird_bus_initiator
  import ladybird_initiator_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  ladybird_bus_interface.primary bus,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("ladybird_bus_initiator: bad CMD_DEPTH or TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  cmd_t        cmd_in, fifo_head, txn_q;
  logic        ready_q, fifo_full, fifo_empty;
  logic        push, pop, cap, timeout, in_req;
  logic [31:0] cap_data, rdata_q;

  assign cmd_in    = {cmd_addr, cmd_wdata, cmd_wstrb};
  // ready_q keeps cmd_ready low through reset and the edge that ends it.
  assign cmd_ready = ready_q & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;

  ladybird_initiator_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cmd_in),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_req    = state_q == S_REQ;
  assign bus.req   = in_req;
  assign bus.addr  = in_req ? txn_q.addr  : 32'h0;
  assign bus.wdata = in_req ? txn_q.wdata : 32'h0;
  assign bus.wstrb = in_req ? txn_q.wstrb : 4'h0;

  assign rsp_valid = state_q == S_RESP;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    cap      = 1'b0;
    cap_data = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.gnt) begin
          if (!is_read(txn_q)) begin
            state_d = S_RESP;
            cap     = 1'b1;
          end else if (bus.rdgnt) begin
            state_d  = S_RESP;
            cap      = 1'b1;
            cap_data = bus.rdata;
          end else begin
            state_d = S_RDWAIT;
          end
        end else if (timeout) begin
          state_d = S_RESP;
          cap     = 1'b1;
        end
      end
      S_RDWAIT: begin
        if (bus.rdgnt) begin
          state_d  = S_RESP;
          cap      = 1'b1;
          cap_data = bus.rdata;
        end else if (timeout) begin
          state_d = S_RESP;
          cap     = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      txn_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (pop) txn_q <= fifo_head;
      if (cap) rdata_q <= cap_data;
    end
  end

`ifdef LADYBIRD_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q;
  logic          err_q, granted;

  assign timeout = to_cnt_q == TO_LAST;
  assign granted = in_req ? bus.gnt : bus.rdgnt;
  assign rsp_err = rsp_valid & err_q;

  // Any state change restarts the count, so each REQ/RDWAIT stay is timed alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_d != state_q) to_cnt_q <= '0;
      else if (in_req || state_q == S_RDWAIT) to_cnt_q <= to_cnt_q + TW'(1);
      if (cap) err_q <= timeout & ~granted;
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_ladybird_bus_initiator.sv
// Randomised bench for ladybird_bus_initiator with a GPIO/memory secondary.
// Responses are predicted from a command-order memory model.
module tb_ladybird_bus_initiator;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic [3:0]  cmd_wstrb;

  always #5 clk = ~clk;

  ladybird_bus_interface bus ();

  ladybird_bus_initiator #(
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Secondary: gnt after gnt_lat waiting cycles, rdgnt rd_lat cycles after gnt.
  int          gnt_lat = 0;
  int          rd_lat  = 0;
  int          req_cnt = 0;
  int          rd_cnt  = 0;
  logic        pend    = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] smem [16] = '{default: 32'h0};
  logic [31:0] led;

  assign led       = smem[2];
  assign bus.gnt   = bus.req && (req_cnt >= gnt_lat);
  assign bus.rdgnt = (bus.req && bus.gnt && bus.wstrb == 4'h0 && rd_lat == 0) ||
                     (pend && rd_cnt >= rd_lat);
  assign bus.rdata = pend ? smem[pend_addr[5:2]] :
                     (bus.req ? smem[bus.addr[5:2]] : 32'h0);

  always @(posedge clk) begin
    if (rst) begin
      req_cnt <= 0;
      rd_cnt  <= 0;
      pend    <= 1'b0;
    end else begin
      if (bus.req && !bus.gnt) req_cnt <= req_cnt + 1;
      else req_cnt <= 0;
      if (bus.req && bus.gnt) begin
        if (bus.wstrb != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (bus.wstrb[b]) smem[bus.addr[5:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
        end else if (rd_lat != 0) begin
          pend      <= 1'b1;
          pend_addr <= bus.addr;
          rd_cnt    <= 1;
        end
      end
      if (pend) begin
        if (bus.rdgnt) pend <= 1'b0;
        else rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Reference model: memory image updated in command order.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic [31:0] ref_mem [16] = '{default: 32'h0};
  exp_t        exp_q [$];
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic logic [31:0] rnd_addr();
    return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  function automatic logic [3:0] rnd_strb();
    return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endfunction

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit drops);
    int i;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    i = 0;
    while (!cmd_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_wait cmd_ready=%b required=1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (drops) begin
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    end else if (s == 4'h0) begin
      exp_q.push_back('{rdata: ref_mem[a[5:2]], err: 1'b0});
    end else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    end
  endtask

  task automatic get_rsp(output bit ok, output logic [31:0] rd, output logic er);
    ok = 1'b0;
    rd = 32'h0;
    er = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, bus.req, rsp_valid, rsp_err} !== 4'b0 ||
        bus.addr !== 32'h0 || bus.wdata !== 32'h0 ||
        bus.wstrb !== 4'h0 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out rdy=%b req=%b addr=%h wd=%h ws=%h rv=%b rd=%h er=%b required all 0",
               cmd_ready, bus.req, bus.addr, bus.wdata, bus.wstrb,
               rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_clk got=%b required=0", cmd_ready);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_clk got=%b required=1", cmd_ready);
    end
  endtask

  task automatic test_gpio_write();
    bit ok;
    logic [31:0] rd;
    logic er;
    exp_t e;
    gnt_lat = 0;
    rd_lat  = 0;
    push_cmd(32'h8, 32'h5, 4'hF, 1'b0);
    vectors++;
    if (bus.req !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_req_early got=%b required=0", bus.req);
    end
    @(negedge clk);
    vectors++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h8 || bus.wdata !== 32'h5 ||
        bus.wstrb !== 4'hF || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_req got req=%b addr=%h wd=%h ws=%h rv=%b required 1/8/5/f/0",
               bus.req, bus.addr, bus.wdata, bus.wstrb, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.req !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 ||
        led !== 32'h5) begin
      miscompares++;
      $display("FAIL wr_rsp got req=%b rv=%b rd=%h led=%h required 0/1/0/5",
               bus.req, rsp_valid, rsp_rdata, led);
    end
    get_rsp(ok, rd, er);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL wr_hs got ok=%b rd=%h er=%b required rd=%h er=%b",
               ok, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_gpio_read();
    bit ok;
    logic [31:0] rd;
    logic er;
    exp_t e;
    push_cmd(32'h8, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h8 || bus.wstrb !== 4'h0) begin
      miscompares++;
      $display("FAIL rd_req got req=%b addr=%h ws=%h required 1/8/0",
               bus.req, bus.addr, bus.wstrb);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5) begin
      miscompares++;
      $display("FAIL rd_lat3 got rv=%b rd=%h required 1/5", rsp_valid, rsp_rdata);
    end
    get_rsp(ok, rd, er);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL rd_hs got ok=%b rd=%h er=%b required rd=%h er=%b",
               ok, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] rd, rd0;
    logic er;
    exp_t e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(rnd_addr(), $urandom, rnd_strb(), 1'b0);
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full got cmd_ready=%b required=0", cmd_ready);
    end
    rd0 = rsp_rdata;
    repeat (2) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold got rv=%b rd=%h rdy=%b required 1/%h/0",
               rsp_valid, rsp_rdata, cmd_ready, rd0);
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp(ok, rd, er);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL b2b_rsp%0d got ok=%b rd=%h er=%b required rd=%h er=%b",
                 i, ok, rd, er, e.rdata, e.err);
      end
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_drain got cmd_ready=%b required=1", cmd_ready);
    end
  endtask

  task automatic test_wait_states();
    bit ok;
    logic [31:0] rd;
    logic er;
    exp_t e;
    int req_cycles, rdw_cycles, addr_bad;
    bit seen_req;
    gnt_lat = 3;
    rd_lat  = 2;
    push_cmd(32'h10, $urandom, 4'hF, 1'b0);
    get_rsp(ok, rd, er);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL ws_wr got ok=%b rd=%h er=%b required rd=%h er=%b",
               ok, rd, er, e.rdata, e.err);
    end
    push_cmd(32'h10, 32'h0, 4'h0, 1'b0);
    req_cycles = 0;
    rdw_cycles = 0;
    addr_bad   = 0;
    seen_req   = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      if (bus.req) begin
        req_cycles++;
        seen_req = 1'b1;
        if (bus.addr !== 32'h10) addr_bad++;
      end else if (seen_req) begin
        rdw_cycles++;
      end
      @(negedge clk);
    end
    vectors++;
    if (req_cycles != 4 || addr_bad != 0) begin
      miscompares++;
      $display("FAIL ws_req got cycles=%0d addr_bad=%0d required 4/0",
               req_cycles, addr_bad);
    end
    vectors++;
    if (rdw_cycles != 2) begin
      miscompares++;
      $display("FAIL ws_rdwait got cycles=%0d required 2", rdw_cycles);
    end
    get_rsp(ok, rd, er);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL ws_rd got ok=%b rd=%h er=%b required rd=%h er=%b",
               ok, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] rd;
    logic er;
    exp_t e;
    int n;
    for (int t = 0; t < 12; t++) begin
      gnt_lat = $urandom_range(0, 3);
      rd_lat  = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++)
        push_cmd(rnd_addr(), $urandom, rnd_strb(), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int i = 0; i < n; i++) begin
        get_rsp(ok, rd, er);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || rd !== e.rdata || er !== e.err) begin
          miscompares++;
          $display("FAIL rnd_%0d_%0d got ok=%b rd=%h er=%b required rd=%h er=%b",
                   t, i, ok, rd, er, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_reset_rdwait();
    int bad;
    gnt_lat = 0;
    rd_lat  = 50;
    push_cmd(rnd_addr(), 32'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.req !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rdwait_entry got req=%b rv=%b required 0/0",
               bus.req, rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.req !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async got req=%b rdy=%b rv=%b required 0/0/0",
               bus.req, cmd_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rd_lat = 0;
    rsp_ready = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || bus.req !== 1'b0) bad++;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (bad != 0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_abandon got bad_cycles=%0d rdy=%b required 0/1",
               bad, cmd_ready);
    end
  endtask

`ifdef LADYBIRD_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    logic [31:0] rd;
    logic er;
    exp_t e;
    int req_cycles;
    gnt_lat = 1000000;
    rd_lat  = 0;
    push_cmd(32'h20, $urandom, 4'hF, 1'b1);
    req_cycles = 0;
    for (int i = 0; i < 50 && !rsp_valid; i++) begin
      if (bus.req) req_cycles++;
      @(negedge clk);
    end
    vectors++;
    if (req_cycles != 8) begin
      miscompares++;
      $display("FAIL to_cycles got=%0d required=8", req_cycles);
    end
    get_rsp(ok, rd, er);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL to_rsp got ok=%b rd=%h er=%b required rd=%h er=%b",
               ok, rd, er, e.rdata, e.err);
    end
    gnt_lat = 0;
    push_cmd(32'h20, 32'h0, 4'h0, 1'b0);
    get_rsp(ok, rd, er);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL to_next got ok=%b rd=%h er=%b required rd=%h er=%b",
               ok, rd, er, e.rdata, e.err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_gpio_write();
    test_gpio_read();
    test_back_to_back();
    test_wait_states();
    test_random();
    test_reset_rdwait();
`ifdef LADYBIRD_INITIATOR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
